// File: rtl/hall_sensor_emulator_pkg.sv
// rtl/hall_sensor_emulator_pkg.sv - shared types, Hall sector table and sector helpers
package hall_sensor_emulator_pkg;

    localparam int RPM_W_DEF = 10;

    typedef logic [2:0] sector_t;

    // {A,B,C} per sector; exactly one line changes between neighbouring sectors
    localparam logic [2:0] HALL_TABLE [6] = '{
        3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
    };

    function automatic logic [2:0] hall_of(input sector_t s);
        return (s <= 3'd5) ? HALL_TABLE[s] : HALL_TABLE[0];
    endfunction

    function automatic sector_t next_sector(input sector_t s, input logic forward);
        if (forward) begin
            return (s >= 3'd5) ? 3'd0 : s + 3'd1;
        end
        return (s == 3'd0 || s > 3'd5) ? 3'd5 : s - 3'd1;
    endfunction

endpackage

// File: rtl/hall_sensor_emulator_bounce.sv
// rtl/hall_sensor_emulator_bounce.sv - contact-bounce injection on the Hall line that just changed
module hall_bounce_injector
    import hall_sensor_emulator_pkg::*;
#(
    parameter int BOUNCE_N   = 2,
    parameter int BOUNCE_GAP = 50
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic       step_pulse,
    input  logic [2:0] clean,
    output logic [2:0] hall
);

    localparam int GW = $clog2(BOUNCE_GAP + 1);
    localparam int TW = $clog2(2 * BOUNCE_N + 2);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(BOUNCE_GAP - 1);
    localparam logic [GW-1:0] GAP_FIRST   = GW'((BOUNCE_GAP > 1) ? BOUNCE_GAP - 2 : 0);
    localparam logic [TW-1:0] LAST_TOGGLE = TW'((BOUNCE_N > 0) ? 2 * BOUNCE_N - 1 : 0);
    localparam bit            IMMEDIATE   = (BOUNCE_GAP == 1);

    logic          active;
    logic [2:0]    line;
    logic [2:0]    flip;
    logic [2:0]    prev;
    logic [GW-1:0] gap;
    logic [TW-1:0] toggles;

    // The gap counter is preloaded so each toggle lands exactly BOUNCE_GAP cycles apart,
    // counting the step_pulse cycle as cycle zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            line    <= 3'b000;
            flip    <= 3'b000;
            prev    <= HALL_TABLE[0];
            gap     <= '0;
            toggles <= '0;
        end else begin
            prev <= clean;
            if (!run || BOUNCE_N == 0) begin
                active <= 1'b0;
                flip   <= 3'b000;
            end else if (step_pulse) begin
                line   <= clean ^ prev;
                active <= 1'b1;
                gap    <= GAP_FIRST;
                if (IMMEDIATE) begin
                    flip    <= clean ^ prev;
                    toggles <= TW'(1);
                end else begin
                    flip    <= 3'b000;
                    toggles <= '0;
                end
            end else if (active) begin
                if (gap == '0) begin
                    flip <= flip ^ line;
                    gap  <= GAP_RELOAD;
                    if (toggles == LAST_TOGGLE) begin
                        active <= 1'b0;
                    end else begin
                        toggles <= toggles + TW'(1);
                    end
                end else begin
                    gap <= gap - GW'(1);
                end
            end
        end
    end

    // A new step discards any bounce still in flight from the previous one.
    assign hall = clean ^ (step_pulse ? 3'b000 : flip);

endmodule

// File: rtl/hall_sensor_emulator.sv
// rtl/hall_sensor_emulator.sv - NCO-driven three-phase Hall sensor generator with command handshake
module hall_sensor_emulator
    import hall_sensor_emulator_pkg::*;
#(
    parameter int RPM_W      = RPM_W_DEF,
    parameter int ACC_W      = 32,
    parameter int INC_SCALE  = 34,
    parameter int BOUNCE_N   = 2,
    parameter int BOUNCE_GAP = 50
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             bounce_en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [RPM_W-1:0] cmd_rpm,
    input  logic             cmd_forward,
    output logic             hall_a,
    output logic             hall_b,
    output logic             hall_c,
    output logic             step_pulse,
    output logic [2:0]       step_idx
);

    if (RPM_W + $clog2(INC_SCALE) > ACC_W) begin : g_bad_width
        $error("hall_sensor_emulator: RPM_W + clog2(INC_SCALE) exceeds ACC_W");
    end

    localparam logic [ACC_W:0] SCALE = (ACC_W + 1)'(INC_SCALE);

    logic [ACC_W-1:0] acc;
    logic [RPM_W-1:0] active_rpm;
    logic             active_forward;
    logic             pend_valid;
    logic [RPM_W-1:0] pend_rpm;
    logic             pend_forward;
    logic [ACC_W:0]   inc;
    logic [ACC_W:0]   sum;
    logic             tick;
    logic             xfer;
    logic             idle;
    logic [2:0]       clean;
    logic [2:0]       hall;

    assign inc  = {{(ACC_W + 1 - RPM_W){1'b0}}, active_rpm} * SCALE;
    assign sum  = {1'b0, acc} + inc;
    assign tick = enable & sum[ACC_W];
    assign xfer = cmd_valid & cmd_ready;
    assign idle = (active_rpm == '0) | ~enable;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            step_idx   <= 3'd0;
            step_pulse <= 1'b0;
        end else begin
            acc        <= enable ? sum[ACC_W-1:0] : '0;
            step_pulse <= tick;
            if (tick) begin
                step_idx <= next_sector(step_idx, active_forward);
            end
        end
    end

    // A pending command swaps in on the tick edge, so that tick still steps in the old direction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready      <= 1'b1;
            active_rpm     <= '0;
            active_forward <= 1'b1;
            pend_valid     <= 1'b0;
            pend_rpm       <= '0;
            pend_forward   <= 1'b1;
        end else if (tick) begin
            if (pend_valid) begin
                active_rpm     <= pend_rpm;
                active_forward <= pend_forward;
                pend_valid     <= 1'b0;
                cmd_ready      <= 1'b1;
            end else if (xfer) begin
                pend_rpm     <= cmd_rpm;
                pend_forward <= cmd_forward;
                pend_valid   <= 1'b1;
                cmd_ready    <= 1'b0;
            end
        end else if (xfer) begin
            if (idle) begin
                active_rpm     <= cmd_rpm;
                active_forward <= cmd_forward;
            end else begin
                pend_rpm     <= cmd_rpm;
                pend_forward <= cmd_forward;
                pend_valid   <= 1'b1;
                cmd_ready    <= 1'b0;
            end
        end
    end

    assign clean = hall_of(step_idx);

    hall_bounce_injector #(
        .BOUNCE_N   (BOUNCE_N),
        .BOUNCE_GAP (BOUNCE_GAP)
    ) u_bounce (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (bounce_en & enable),
        .step_pulse (step_pulse),
        .clean      (clean),
        .hall       (hall)
    );

    assign {hall_a, hall_b, hall_c} = hall;

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// tb/tb_hall_sensor_emulator.sv - directed scoreboard bench for clean and bouncing emulator instances
module tb_hall_sensor_emulator;

    typedef struct {
        int cyc;
        int idx;
    } exp_t;

    localparam logic [2:0] HT [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b1;
    logic       bounce_en = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_rpm = '0;
    logic       cmd_forward = 1'b1;

    logic       cmd_ready0, hall_a0, hall_b0, hall_c0, step_pulse0;
    logic       cmd_ready1, hall_a1, hall_b1, hall_c1, step_pulse1;
    logic [2:0] step_idx0, step_idx1;
    logic [2:0] hall0, hall1;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    assign hall0 = {hall_a0, hall_b0, hall_c0};
    assign hall1 = {hall_a1, hall_b1, hall_c1};

    hall_sensor_emulator #(
        .RPM_W(10), .ACC_W(16), .INC_SCALE(1), .BOUNCE_N(0), .BOUNCE_GAP(50)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .bounce_en(bounce_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0), .cmd_rpm(cmd_rpm),
        .cmd_forward(cmd_forward), .hall_a(hall_a0), .hall_b(hall_b0), .hall_c(hall_c0),
        .step_pulse(step_pulse0), .step_idx(step_idx0)
    );

    hall_sensor_emulator #(
        .RPM_W(10), .ACC_W(16), .INC_SCALE(1), .BOUNCE_N(2), .BOUNCE_GAP(10)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .bounce_en(bounce_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1), .cmd_rpm(cmd_rpm),
        .cmd_forward(cmd_forward), .hall_a(hall_a1), .hall_b(hall_b1), .hall_c(hall_c1),
        .step_pulse(step_pulse1), .step_idx(step_idx1)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic sample(input int c);
        goto(c);
        @(negedge clock);
    endtask

    task automatic push_steps(input int first, input int period, input int from_idx,
                              input bit fwd, input int n);
        int idx;
        idx = from_idx;
        for (int i = 0; i < n; i++) begin
            idx = fwd ? (idx + 1) % 6 : (idx + 5) % 6;
            sb.push_back('{first + i * period, idx});
        end
    endtask

    task automatic command(input int rpm, input bit fwd);
        cmd_valid   = 1'b1;
        cmd_rpm     = 10'(rpm);
        cmd_forward = fwd;
    endtask

    task automatic check_idle(input string tag, input int idx, input logic ready);
        check({tag, "_idx"}, 32'(step_idx0), 32'(idx));
        check({tag, "_hall0"}, 32'(hall0), 32'(HT[idx]));
        check({tag, "_hall1"}, 32'(hall1), 32'(HT[idx]));
        check({tag, "_ready"}, 32'(cmd_ready0), 32'(ready));
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1 && (step_pulse0 === 1'b1 || step_pulse1 === 1'b1)) begin
            check("pulse_match", 32'(step_pulse1), 32'(step_pulse0));
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("pulse_idx0", 32'(step_idx0), 32'(mon_e.idx));
                check("pulse_idx1", 32'(step_idx1), 32'(mon_e.idx));
                check("pulse_hall0", 32'(hall0), 32'(HT[mon_e.idx]));
                check("pulse_hall1", 32'(hall1), 32'(HT[mon_e.idx]));
            end
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        sample(2);
        check_idle("reset", 0, 1'b1);
        check("reset_pulse", 32'(step_pulse0), 32'd0);
        check("reset_ready1", 32'(cmd_ready1), 32'd1);
        goto(5);
        reset_n = 1'b1;

        // forward at 256 rpm: one step every 256 cycles, first one 257 cycles after the command
        goto(10);
        command(256, 1'b1);
        push_steps(267, 256, 0, 1'b1, 6);
        sample(10);
        check("load_ready_a", 32'(cmd_ready0), 32'd1);
        goto(11);
        cmd_valid = 1'b0;
        sample(11);
        check("load_ready_b", 32'(cmd_ready0), 32'd1);

        // bounce on the C line after 101 -> 100
        sample(266); check("bnc_pre", 32'(hall1), 32'(3'b101));
        sample(267); check("bnc_edge", 32'(hall1), 32'(3'b100));
        sample(276); check("bnc_p9", 32'(hall1), 32'(3'b100));
        sample(277); check("bnc_p10", 32'(hall1), 32'(3'b101));
        check("bnc_clean0", 32'(hall0), 32'(3'b100));
        sample(286); check("bnc_p19", 32'(hall1), 32'(3'b101));
        sample(287); check("bnc_p20", 32'(hall1), 32'(3'b100));
        sample(297); check("bnc_p30", 32'(hall1), 32'(3'b101));
        sample(307); check("bnc_p40", 32'(hall1), 32'(3'b100));
        sample(320); check("bnc_end", 32'(hall1), 32'(3'b100));

        // bounce_en dropped mid-bounce after 100 -> 110
        sample(533); check("bof_toggled", 32'(hall1), 32'(3'b100));
        goto(538);
        bounce_en = 1'b0;
        sample(538); check("bof_same_cycle", 32'(hall1), 32'(3'b100));
        sample(539); check("bof_next_cycle", 32'(hall1), 32'(3'b110));
        goto(600);
        bounce_en = 1'b1;

        // mid-sector reverse 512 rpm: waits for the next tick, which still steps forward
        goto(1675);
        command(512, 1'b0);
        push_steps(1803, 128, 0, 1'b1, 1);
        push_steps(1931, 128, 1, 1'b0, 3);
        goto(1676);
        cmd_valid = 1'b0;
        sample(1676); check("pend_ready_lo", 32'(cmd_ready0), 32'd0);
        sample(1802); check("pend_ready_tick", 32'(cmd_ready0), 32'd0);
        sample(1803); check("pend_ready_back", 32'(cmd_ready0), 32'd1);

        // enable low for 1000 cycles: frozen outputs, accumulator cleared
        goto(2237);
        enable = 1'b0;
        sample(2500);
        check_idle("disabled", 4, 1'b1);
        check("disabled_pulse", 32'(step_pulse0), 32'd0);
        goto(3237);
        enable = 1'b1;
        push_steps(3365, 128, 4, 1'b0, 2);

        // rpm=0 while running is pending until the next tick, then holds
        goto(3503);
        command(0, 1'b1);
        push_steps(3621, 128, 2, 1'b0, 1);
        goto(3504);
        cmd_valid = 1'b0;
        sample(3504); check("zero_pend_ready", 32'(cmd_ready0), 32'd0);
        sample(3621); check("zero_commit_ready", 32'(cmd_ready0), 32'd1);
        sample(4200);
        check_idle("stopped", 1, 1'b1);

        // restart from standstill is accepted immediately
        goto(4300);
        command(256, 1'b1);
        push_steps(4557, 256, 1, 1'b1, 1);
        sample(4300); check("restart_ready_a", 32'(cmd_ready0), 32'd1);
        goto(4301);
        cmd_valid = 1'b0;
        sample(4301); check("restart_ready_b", 32'(cmd_ready0), 32'd1);

        // reset mid-bounce with a pending command
        goto(4560);
        command(100, 1'b0);
        goto(4561);
        cmd_valid = 1'b0;
        sample(4561); check("rst_pend_ready", 32'(cmd_ready0), 32'd0);
        sample(4571); check("rst_pre_bounce", 32'(hall1), 32'(3'b100));
        goto(4572);
        reset_n = 1'b0;
        #1;
        check_idle("async_rst", 0, 1'b1);
        check("async_rst_ready1", 32'(cmd_ready1), 32'd1);
        check("async_rst_pulse", 32'(step_pulse1), 32'd0);
        goto(4580);
        reset_n = 1'b1;
        sample(5300);
        check_idle("post_rst", 0, 1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
